// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch and data access.
// Data wins by default; after STARVE_LIMIT back-to-back data grants with a fetch waiting, fetch wins once.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush_if,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [3:0]        streak_q, streak_d;
    logic              drop_q, drop_d;

    logic              fetch_forced;

    assign fetch_forced = dm_req & if_req & (streak_q == LIMIT);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        streak_d    = streak_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (dm_req && !fetch_forced) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    if (!if_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q != LIMIT) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (if_req) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    streak_d    = 4'd0;
                end
            end

            FETCH: begin
                // A redirect cannot cancel the bus cycle, so only its result is discarded.
                if (flush_if) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end
            end

            DATA: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            streak_q    <= 4'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    // Readies are gated by rst_n so an ack landing in a reset cycle is never reported.
    assign dm_ready  = rst_n & mem_ack & (state_q == DATA);
    assign if_ready  = rst_n & mem_ack & (state_q == FETCH) & ~drop_q & ~flush_if;
    assign dm_rdata  = mem_rdata;
    assign if_rdata  = mem_rdata;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req, flush_if, dm_req, dm_we, mem_ack;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata, mem_rdata;
   logic [3:0]    dm_be;
   logic          if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_ready(if_ready),
      .if_rdata(if_rdata),
      .flush_if(flush_if),
      .dm_req(dm_req),
      .dm_we(dm_we),
      .dm_addr(dm_addr),
      .dm_wdata(dm_wdata),
      .dm_be(dm_be),
      .dm_ready(dm_ready),
      .dm_rdata(dm_rdata),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_be(mem_be),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack),
      .stall_if(stall_if),
      .stall_mem(stall_mem)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge so registered outputs are settled.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      if_req   = 1'b0;
      flush_if = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      mem_ack  = 1'b0;
   endtask

   // Reset values of every registered output, plus readies suppressed while in reset.
   task automatic test_reset;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) tick();
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%0h exp=0", mem_req); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%0h exp=0", mem_we); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
      total++; if (mem_be !== 4'h0) begin bad++; $display("[TB] FAIL reset_mem_be got=%0h exp=0", mem_be); end
      mem_ack = 1'b1;
      #1;
      total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_dm_ready got=%0h exp=0", dm_ready); end
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_ready got=%0h exp=0", if_ready); end
      tick();
      mem_ack = 1'b0;
      rst_n   = 1'b1;
      tick();
   endtask

   // Single load with the ack arriving three cycles after mem_req rises.
   task automatic test_single_load;
      int pulses;
      pulses = 0;
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h0; dm_be = 4'hF;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL load_grant_cycle_mem_req got=%0h exp=0", mem_req); end
      total++; if (stall_mem !== 1'b1) begin bad++; $display("[TB] FAIL load_stall_first got=%0h exp=1", stall_mem); end
      for (int c = 0; c < 4; c++) begin
         tick();
         mem_ack   = (c == 3);
         mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
         #1;
         total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL load_mem_req c=%0d got=%0h exp=1", c, mem_req); end
         total++; if (mem_addr !== 32'h100) begin bad++; $display("[TB] FAIL load_mem_addr c=%0d got=%0h exp=100", c, mem_addr); end
         total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL load_mem_we c=%0d got=%0h exp=0", c, mem_we); end
         total++; if (stall_mem !== (c != 3)) begin bad++; $display("[TB] FAIL load_stall c=%0d got=%0h exp=%0h", c, stall_mem, (c != 3)); end
         if (dm_ready === 1'b1) pulses++;
         if (c == 3) begin
            total++; if (dm_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_rdata got=%0h exp=deadbeef", dm_rdata); end
         end
      end
      tick();
      dm_req = 1'b0; mem_ack = 1'b0;
      #1;
      if (dm_ready === 1'b1) pulses++;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL load_mem_req_drop got=%0h exp=0", mem_req); end
      total++; if (pulses != 1) begin bad++; $display("[TB] FAIL load_ready_pulses got=%0d exp=1", pulses); end
   endtask

   // Both stages request together: data first, then fetch.
   task automatic test_simultaneous;
      tick();
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'hF;
      #1;
      total++; if (stall_if !== 1'b1) begin bad++; $display("[TB] FAIL simul_stall_if_0 got=%0h exp=1", stall_if); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      #1;
      total++; if (mem_addr !== 32'h200) begin bad++; $display("[TB] FAIL simul_first_addr got=%0h exp=200", mem_addr); end
      total++; if (dm_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_dm_ready got=%0h exp=1", dm_ready); end
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL simul_if_ready_early got=%0h exp=0", if_ready); end
      total++; if (stall_if !== 1'b1) begin bad++; $display("[TB] FAIL simul_stall_if_1 got=%0h exp=1", stall_if); end
      tick();
      dm_req = 1'b0; mem_ack = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL simul_idle_mem_req got=%0h exp=0", mem_req); end
      total++; if (stall_if !== 1'b1) begin bad++; $display("[TB] FAIL simul_stall_if_2 got=%0h exp=1", stall_if); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h33334444;
      #1;
      total++; if (mem_addr !== 32'h40) begin bad++; $display("[TB] FAIL simul_second_addr got=%0h exp=40", mem_addr); end
      total++; if (mem_be !== 4'hF) begin bad++; $display("[TB] FAIL simul_fetch_be got=%0h exp=f", mem_be); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL simul_fetch_we got=%0h exp=0", mem_we); end
      total++; if (if_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_if_ready got=%0h exp=1", if_ready); end
      total++; if (if_rdata !== 32'h33334444) begin bad++; $display("[TB] FAIL simul_if_rdata got=%0h exp=33334444", if_rdata); end
      total++; if (stall_if !== 1'b0) begin bad++; $display("[TB] FAIL simul_stall_if_3 got=%0h exp=0", stall_if); end
      tick();
      if_req = 1'b0; mem_ack = 1'b0;
   endtask

   // Both requests held: every (LIMIT+1)th grant must go to fetch.
   task automatic test_starvation;
      int grants;
      logic [31:0] exp_addr;
      grants = 0;
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF;
      if_req = 1'b1; if_addr = 32'h300;
      for (int c = 0; c < 60 && grants < 10; c++) begin
         mem_ack   = mem_req;
         mem_rdata = 32'h0;
         #1;
         if (mem_req === 1'b1) begin
            exp_addr = ((grants % (LIMIT + 1)) == LIMIT) ? 32'h300 : 32'h400;
            total++; if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL starve_grant%0d_addr got=%0h exp=%0h", grants, mem_addr, exp_addr); end
            grants++;
         end
         tick();
      end
      dm_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
      total++; if (grants != 10) begin bad++; $display("[TB] FAIL starve_grant_count got=%0d exp=10", grants); end
      tick();
   endtask

   // Redirect during a fetch: the result is swallowed, the next fetch completes normally.
   task automatic test_flush;
      tick();
      if_req = 1'b1; if_addr = 32'h80;
      #1;
      tick();
      flush_if = 1'b1; if_req = 1'b0;
      #1;
      total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL flush_mem_req got=%0h exp=1", mem_req); end
      total++; if (mem_addr !== 32'h80) begin bad++; $display("[TB] FAIL flush_mem_addr got=%0h exp=80", mem_addr); end
      tick();
      flush_if = 1'b0;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_if_ready_wait got=%0h exp=0", if_ready); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
      #1;
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_if_ready_dropped got=%0h exp=0", if_ready); end
      tick();
      mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h90;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL flush_idle_mem_req got=%0h exp=0", mem_req); end
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0000C0DE;
      #1;
      total++; if (mem_addr !== 32'h90) begin bad++; $display("[TB] FAIL flush_next_addr got=%0h exp=90", mem_addr); end
      total++; if (if_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_next_ready got=%0h exp=1", if_ready); end
      total++; if (if_rdata !== 32'h0000C0DE) begin bad++; $display("[TB] FAIL flush_next_rdata got=%0h exp=c0de", if_rdata); end
      tick();
      if_req = 1'b0; mem_ack = 1'b0;
   endtask

   // Partial store: write fields held stable until the ack.
   task automatic test_store;
      tick();
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'h1234ABCD; dm_addr = 32'h500;
      #1;
      for (int c = 0; c < 4; c++) begin
         tick();
         mem_ack = (c == 3); mem_rdata = $urandom;
         #1;
         total++; if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL store_we c=%0d got=%0h exp=1", c, mem_we); end
         total++; if (mem_be !== 4'b0011) begin bad++; $display("[TB] FAIL store_be c=%0d got=%0h exp=3", c, mem_be); end
         total++; if (mem_wdata !== 32'h1234ABCD) begin bad++; $display("[TB] FAIL store_wdata c=%0d got=%0h exp=1234abcd", c, mem_wdata); end
         total++; if (mem_addr !== 32'h500) begin bad++; $display("[TB] FAIL store_addr c=%0d got=%0h exp=500", c, mem_addr); end
         total++; if (dm_ready !== (c == 3)) begin bad++; $display("[TB] FAIL store_ready c=%0d got=%0h exp=%0h", c, dm_ready, (c == 3)); end
      end
      tick();
      dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      #1;
      total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL store_ready_after got=%0h exp=0", dm_ready); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL store_mem_req_after got=%0h exp=0", mem_req); end
   endtask

   // Reset during a data access abandons it; a late ack is ignored.
   task automatic test_reset_mid;
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
      #1;
      tick();
      #1;
      total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_inflight got=%0h exp=1", mem_req); end
      tick();
      rst_n = 1'b0;
      #1;
      total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ready_in_reset got=%0h exp=0", dm_ready); end
      tick();
      rst_n = 1'b1; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_mem_req got=%0h exp=0", mem_req); end
      total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_late_dm_ready got=%0h exp=0", dm_ready); end
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_late_if_ready got=%0h exp=0", if_ready); end
      tick();
      mem_ack = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_regrant got=%0h exp=0", mem_req); end
   endtask

   // Random requesters, random memory latency, random redirects and spurious acks,
   // checked against a transaction-level model of the arbitration rules.
   task automatic test_random;
      bit          busy = 1'b0, cur_fetch = 1'b0, dropped = 1'b0, cur_we = 1'b0;
      bit          f_act = 1'b0, d_act = 1'b0;
      bit          ack, flush_now, exp_ir, exp_dr;
      logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
      logic [3:0]  cur_be = 4'h0;
      int          lat = 0, streak_m = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         flush_now = ($urandom_range(0, 15) == 0);
         if (flush_now) begin
            f_act = 1'b0;
         end else if (!f_act && $urandom_range(0, 2) == 0) begin
            f_act = 1'b1; if_addr = $urandom;
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1'b1; dm_we = 1'($urandom_range(0, 1));
            dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
         end
         ack = busy ? (lat == 0) : ($urandom_range(0, 7) == 0);
         if_req = f_act; dm_req = d_act; flush_if = flush_now;
         mem_ack = ack; mem_rdata = $urandom;
         #1;
         exp_dr = busy && ack && !cur_fetch;
         exp_ir = busy && ack && cur_fetch && !dropped && !flush_now;
         total++; if (mem_req !== busy) begin bad++; $display("[TB] FAIL rnd_mem_req cyc=%0d got=%0h exp=%0h", cyc, mem_req, busy); end
         if (busy) begin
            total++; if (mem_addr !== cur_addr) begin bad++; $display("[TB] FAIL rnd_mem_addr cyc=%0d got=%0h exp=%0h", cyc, mem_addr, cur_addr); end
            total++; if (mem_we !== cur_we) begin bad++; $display("[TB] FAIL rnd_mem_we cyc=%0d got=%0h exp=%0h", cyc, mem_we, cur_we); end
            total++; if (mem_be !== cur_be) begin bad++; $display("[TB] FAIL rnd_mem_be cyc=%0d got=%0h exp=%0h", cyc, mem_be, cur_be); end
            if (!cur_fetch) begin
               total++; if (mem_wdata !== cur_wdata) begin bad++; $display("[TB] FAIL rnd_mem_wdata cyc=%0d got=%0h exp=%0h", cyc, mem_wdata, cur_wdata); end
            end
         end
         total++; if (dm_ready !== exp_dr) begin bad++; $display("[TB] FAIL rnd_dm_ready cyc=%0d got=%0h exp=%0h", cyc, dm_ready, exp_dr); end
         total++; if (if_ready !== exp_ir) begin bad++; $display("[TB] FAIL rnd_if_ready cyc=%0d got=%0h exp=%0h", cyc, if_ready, exp_ir); end
         if (exp_dr && !cur_we) begin
            total++; if (dm_rdata !== mem_rdata) begin bad++; $display("[TB] FAIL rnd_dm_rdata cyc=%0d got=%0h exp=%0h", cyc, dm_rdata, mem_rdata); end
         end
         if (exp_ir) begin
            total++; if (if_rdata !== mem_rdata) begin bad++; $display("[TB] FAIL rnd_if_rdata cyc=%0d got=%0h exp=%0h", cyc, if_rdata, mem_rdata); end
         end
         total++; if (stall_if !== (f_act && !exp_ir)) begin bad++; $display("[TB] FAIL rnd_stall_if cyc=%0d got=%0h exp=%0h", cyc, stall_if, (f_act && !exp_ir)); end
         total++; if (stall_mem !== (d_act && !exp_dr)) begin bad++; $display("[TB] FAIL rnd_stall_mem cyc=%0d got=%0h exp=%0h", cyc, stall_mem, (d_act && !exp_dr)); end

         if (busy) begin
            if (cur_fetch && flush_now) dropped = 1'b1;
            if (ack) begin
               busy = 1'b0;
               if (exp_ir) f_act = 1'b0;
               if (exp_dr) d_act = 1'b0;
            end else begin
               lat--;
            end
         end else if (d_act || f_act) begin
            cur_fetch = f_act && (!d_act || streak_m >= LIMIT);
            if (cur_fetch) streak_m = 0;
            else           streak_m = f_act ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
            cur_addr  = cur_fetch ? if_addr : dm_addr;
            cur_we    = cur_fetch ? 1'b0 : dm_we;
            cur_wdata = dm_wdata;
            cur_be    = cur_fetch ? 4'hF : dm_be;
            busy      = 1'b1;
            dropped   = 1'b0;
            lat       = $urandom_range(0, 3);
         end
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = 4'h0; mem_rdata = '0;
      test_reset();
      test_single_load();
      test_simultaneous();
      test_starvation();
      test_flush();
      test_store();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

endmodule
